// File: rtl/data_logger.sv
// data_logger: leveled event logger. Accepted events are timestamped, tagged with
// NAME_ID and queued in a first-word-fall-through FIFO that drains as a record stream.
//
// Handshakes: a transfer happens on any rising edge where valid and ready are both 1.
// Input side: log_ready is tied high, so every log_valid cycle is an accept cycle; events
// that cannot be stored are filtered or counted as drops rather than stalled.
// Output side: rec_valid stays high and rec_data stays stable until rec_ready is seen.
module data_logger #(
  parameter logic [7:0] NAME_ID   = 8'h00,
  parameter int         VERBOSITY = 3,
  parameter int         DEPTH     = 16,
  parameter int         TS_W      = 32
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic                       log_valid,
  output logic                       log_ready,
  input  logic [2:0]                 log_level,
  input  logic [15:0]                log_code,
  input  logic [31:0]                log_arg,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [TS_W+58:0]           rec_data,
  output logic                       fatal,
  output logic [15:0]                drop_cnt,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int RW    = TS_W + 59;

  logic [RW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [TS_W-1:0]  ts_q;

  logic level_ok;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic [RW-1:0] new_rec;

  assign log_ready = 1'b1;

  // Decode the level filter and the FIFO push/pop/drop decisions for this cycle.
  always_comb begin
    level_ok = (log_level != 3'd0) && (log_level <= 3'd4) && (int'(log_level) <= VERBOSITY);
    full     = (count_q == CNT_W'(DEPTH));
    pop      = rec_valid && rec_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push     = log_valid && level_ok && (!full || pop);
    drop     = log_valid && level_ok && full && !pop;
    new_rec  = {ts_q, NAME_ID, log_level, log_code, log_arg};
  end

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) ts_q <= '0;
    else         ts_q <= ts_q + 1'b1;
  end

  // Record storage; contents are only observable when count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_rec;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky fatal flag and saturating drop counter.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      fatal    <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (log_valid && level_ok && (log_level == 3'd1)) fatal <= 1'b1;
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Output view of the head record; reads zero whenever the FIFO is empty.
  always_comb begin
    count     = count_q;
    rec_valid = (count_q != '0);
    rec_data  = rec_valid ? mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_data_logger.sv
// tb_data_logger: directed checks of filtering, timestamping, overflow, full push/pop,
// reset and back-pressure for data_logger.
module tb_data_logger;

  localparam logic [7:0] NAME  = 8'hA5;
  localparam int         VERB  = 3;
  localparam int         DEPTH = 16;
  localparam int         RW    = 32 + 59;

  logic          clk = 1'b0;
  logic          resetb;
  logic          log_valid;
  logic          log_ready;
  logic [2:0]    log_level;
  logic [15:0]   log_code;
  logic [31:0]   log_arg;
  logic          rec_valid;
  logic          rec_ready;
  logic [RW-1:0] rec_data;
  logic          fatal;
  logic [15:0]   drop_cnt;
  logic [4:0]    count;

  int checks   = 0;
  int failures = 0;

  logic [RW-1:0] exp_q[$];
  logic          exp_fatal;
  logic [15:0]   exp_drop;
  logic [31:0]   tb_ts;

  data_logger #(.NAME_ID(NAME), .VERBOSITY(VERB), .DEPTH(DEPTH), .TS_W(32)) dut (
    .clk(clk), .resetb(resetb),
    .log_valid(log_valid), .log_ready(log_ready), .log_level(log_level),
    .log_code(log_code), .log_arg(log_arg),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .fatal(fatal), .drop_cnt(drop_cnt), .count(count)
  );

  // Clock and reference timestamp.
  always #5 clk = ~clk;

  always @(posedge clk or negedge resetb) begin
    if (!resetb) tb_ts <= '0;
    else         tb_ts <= tb_ts + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_fatal = 1'b0;
    exp_drop  = '0;
  endtask

  // One clock: drive inputs at the falling edge, check outputs, update the model.
  task automatic cycle(input logic v, input logic [2:0] lvl, input logic [15:0] code,
                       input logic [31:0] arg, input logic rdy);
    logic pop;
    logic ok;
    log_valid = v;
    log_level = lvl;
    log_code  = code;
    log_arg   = arg;
    rec_ready = rdy;
    check("rec_valid", rec_valid, exp_q.size() != 0);
    check("count", count, exp_q.size());
    if (exp_q.size() != 0) check("rec_data", rec_data, exp_q[0]);
    check("fatal", fatal, exp_fatal);
    check("drop_cnt", drop_cnt, exp_drop);
    check("log_ready", log_ready, 1'b1);
    pop = (exp_q.size() != 0) && rdy;
    ok  = v && (lvl >= 3'd1) && (lvl <= 3'd4) && (int'(lvl) <= VERB);
    if (ok && lvl == 3'd1) exp_fatal = 1'b1;
    if (pop) void'(exp_q.pop_front());
    if (ok) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({tb_ts, NAME, lvl, code, arg});
      else if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 3'd0, 16'h0, 32'h0, rdy);
  endtask

  initial begin
    resetb = 1'b0; log_valid = 1'b0; log_level = '0; log_code = '0; log_arg = '0;
    rec_ready = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    check("rst_valid", rec_valid, 1'b0);
    check("rst_data", rec_data, '0);
    check("rst_count", count, 5'd0);
    check("rst_fatal", fatal, 1'b0);
    check("rst_drop", drop_cnt, 16'd0);
    resetb = 1'b1;

    // Timestamp and tag: event accepted on the 11th edge after reset release carries ts 10.
    repeat (10) idle(1'b0);
    cycle(1'b1, 3'd3, 16'h1234, 32'hDEADBEEF, 1'b0);
    check("t3_valid", rec_valid, 1'b1);
    check("t3_rec", rec_data, {32'd10, 8'hA5, 3'd3, 16'h1234, 32'hDEADBEEF});
    idle(1'b1);
    idle(1'b0);

    // Level filtering: levels 4,3,2,1,0,7 with codes 1..6.
    for (int i = 0; i < 6; i++) begin
      logic [2:0] lv;
      case (i)
        0: lv = 3'd4; 1: lv = 3'd3; 2: lv = 3'd2;
        3: lv = 3'd1; 4: lv = 3'd0; default: lv = 3'd7;
      endcase
      cycle(1'b1, lv, 16'(i + 1), 32'(i * 3), 1'b0);
    end
    check("t2_count", count, 5'd3);
    check("t2_fatal", fatal, 1'b1);
    check("t2_drop", drop_cnt, 16'd0);
    for (int i = 0; i < 3; i++) begin
      check("t2_code", rec_data[47:32], 16'(2 + i));
      check("t2_level", rec_data[50:48], 3'(3 - i));
      idle(1'b1);
    end
    check("t2_empty", count, 5'd0);

    // Reset mid-stream with three records queued.
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'd3, 16'h50 + 16'(i), 32'h0, 1'b0);
    resetb = 1'b0;
    #1;
    check("t1_count", count, 5'd0);
    check("t1_valid", rec_valid, 1'b0);
    check("t1_fatal", fatal, 1'b0);
    check("t1_drop", drop_cnt, 16'd0);
    clear_model();
    @(negedge clk);
    resetb = 1'b1;
    cycle(1'b1, 3'd3, 16'h77, 32'h1, 1'b0);
    check("t1_ts0", rec_data[90:59], 32'd0);
    idle(1'b1);

    // Overflow: 20 INFO events with the sink stalled.
    for (int i = 0; i < 20; i++) cycle(1'b1, 3'd3, 16'd100 + 16'(i), 32'(i), 1'b0);
    check("t4_count", count, 5'd16);
    check("t4_drop", drop_cnt, 16'd4);
    for (int i = 0; i < 16; i++) begin
      check("t4_code", rec_data[47:32], 16'd100 + 16'(i));
      idle(1'b1);
    end
    check("t4_empty", count, 5'd0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 16; i++) cycle(1'b1, 3'd3, 16'd200 + 16'(i), 32'(i), 1'b0);
    check("t5_full", count, 5'd16);
    cycle(1'b1, 3'd3, 16'd216, 32'h0, 1'b1);
    check("t5_count", count, 5'd16);
    check("t5_drop", drop_cnt, 16'd4);
    for (int i = 0; i < 16; i++) begin
      check("t5_code", rec_data[47:32], 16'd201 + 16'(i));
      idle(1'b1);
    end

    // Back-pressure: random sink stalls over 100 events.
    for (int i = 0; i < 100; i++)
      cycle(1'b1, 3'($urandom_range(2, 4)), 16'd1000 + 16'(i), $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) idle(1'($urandom_range(0, 1)));
    check("t6_empty", count, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
